// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous line that idles high
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the raw input through the chain; resets to idle-high so no false start
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff <= '1;
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling 8N1 UART receiver with ready/clear handshake
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_enb,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
  rx_state_e state, state_d;
  logic rx_s, good, bad;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );
  // frame state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RX_IDLE;
    else state <= state_d;
  // next state; good/bad mark the mid-stop-bit sample with a high or low line
  always_comb begin
    state_d = state;
    busy = state != RX_IDLE;
    good = 1'b0;
    bad = 1'b0;
    case (state)
      RX_IDLE:  state_d = rx_enb && !rx_s ? RX_START : RX_IDLE;
      RX_START: if (rx_enb && tick_cnt == T_MID) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_enb && tick_cnt == T_END && bit_cnt == B_END) state_d = RX_STOP;
      RX_STOP: if (rx_enb && tick_cnt == T_END) begin
        state_d = RX_IDLE;
        good = rx_s;
        bad = !rx_s;
      end
      default:  state_d = RX_IDLE;
    endcase
  end
  // tick/bit counters and LSB-first shift register, advanced only on baud ticks
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
    end else if (rx_enb) begin
      tick_cnt <= state == RX_IDLE || state_d != state || tick_cnt == T_END ? '0 : tick_cnt + 1'b1;
      bit_cnt <= state == RX_DATA ? bit_cnt + BW'(tick_cnt == T_END) : '0;
      if (state == RX_DATA && tick_cnt == T_END) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  // output registers; a completing good frame wins over a coincident clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_out <= '0;
      rdy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data_out <= good ? shreg : data_out;
      rdy <= good | (rdy & ~rdy_clr);
      overrun <= ~rdy_clr & (overrun | (good & rdy));
      frame_err <= bad | (frame_err & ~good);
    end
endmodule
